// File: rtl/arb16_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
// Sized for a single 4:16 one-hot select decode.
package arb16_pkg;

    localparam int NREQ = 16;
    localparam int IDXW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDXW-1:0] inc_sat(input logic [IDXW-1:0] val);
        logic [IDXW-1:0] res;
        res = val;
        if (val != {IDXW{1'b1}}) begin
            res = val + IDXW'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 15 -> 0.
// Rotate so ptr lands at bit 0, fixed-priority encode, then add ptr back.
module rr_pick16
    import arb16_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] pick_idx,
    output logic            pick_valid
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IDXW-1:0]   rot_off;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NREQ];

    // Descending scan so the lowest set bit of the rotated vector wins.
    always_comb begin
        rot_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_off = IDXW'(i);
            end
        end
    end

    assign pick_idx   = ptr + rot_off;
    assign pick_valid = |req;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters sharing one one-hot select line.
// Grants are registered; an idle cycle always separates consecutive grants.
//
//   state | meaning
//   IDLE  | no grant; pick next requester from ptr upward
//   BUSY  | one grant held until done, withdraw or hold limit
module rr_arbiter16
    import arb16_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [IDXW-1:0] HOLD_LAST = IDXW'(MAX_HOLD - 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDXW-1:0] gnt_idx_d;
    logic            gnt_valid_d;
    logic            timeout_d;

    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic            held_req;
    logic            hit_limit;
    logic            release_now;

    rr_pick16 u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign held_req    = req[gnt_idx];
    assign hit_limit   = (hold_cnt_q == HOLD_LAST);
    assign release_now = done || !held_req || hit_limit;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt;
        gnt_idx_d   = gnt_idx;
        gnt_valid_d = gnt_valid;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = BUSY;
                    gnt_d       = idx_to_onehot(pick_idx);
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx + IDXW'(1);
                    // Done and withdraw outrank the limit: only a pure hold-limit release pulses.
                    timeout_d   = !done && held_req && hit_limit;
                end else begin
                    hold_cnt_d = inc_sat(hold_cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_valid  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt        <= gnt_d;
            gnt_idx    <= gnt_idx_d;
            gnt_valid  <= gnt_valid_d;
            timeout    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 using a holder/occupancy reference model.
// Directed scenarios first, then a randomized run against the same model.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who holds the resource, for how many cycles, and where the search starts.
    int          m_holder = -1;
    int          m_ptr    = 0;
    int          m_occ    = 0;
    logic        m_to     = 1'b0;
    logic [15:0] e_gnt    = '0;
    logic [3:0]  e_idx    = '0;
    logic        e_valid  = 1'b0;
    logic        e_to     = 1'b0;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic [15:0] r, input logic d, input logic rs);
        if (rs) begin
            m_holder = -1;
            m_ptr    = 0;
            m_occ    = 0;
            m_to     = 1'b0;
        end else if (m_holder < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 16; k++) begin
                int j;
                j = (m_ptr + k) % 16;
                if (m_holder < 0 && r[j]) begin
                    m_holder = j;
                    m_occ    = 1;
                end
            end
        end else begin
            if (d || !r[m_holder]) begin
                m_to     = 1'b0;
                m_ptr    = (m_holder + 1) % 16;
                m_holder = -1;
            end else if (m_occ >= MAX_HOLD) begin
                m_to     = 1'b1;
                m_ptr    = (m_holder + 1) % 16;
                m_holder = -1;
            end else begin
                m_occ = m_occ + 1;
                m_to  = 1'b0;
            end
        end
        e_valid = (m_holder >= 0);
        e_gnt   = e_valid ? (16'd1 << m_holder) : 16'd0;
        e_idx   = e_valid ? 4'(m_holder) : 4'd0;
        e_to    = m_to;
    endtask

    task automatic tick(input logic [15:0] r, input logic d, input logic rs);
        req   = r;
        done  = d;
        reset = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
    endtask

    task automatic test_reset();
        tick(16'hFFFF, 1'b0, 1'b1);
        n_checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 22'd0)
            $display("FAIL reset_outputs got gnt=%h idx=%0d v=%b to=%b want all zero", gnt, gnt_idx, gnt_valid, timeout);
        else n_pass++;
        tick(16'h0000, 1'b1, 1'b0);
        n_checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 22'd0)
            $display("FAIL reset_idle_hold got gnt=%h idx=%0d v=%b to=%b want all zero", gnt, gnt_idx, gnt_valid, timeout);
        else n_pass++;
    endtask

    task automatic test_single();
        tick(16'h0000, 1'b0, 1'b1);
        tick(16'h0001, 1'b0, 1'b0);
        n_checks++;
        if (gnt !== 16'h0001 || gnt_idx !== 4'd0 || gnt_valid !== 1'b1)
            $display("FAIL single_grant got gnt=%h idx=%0d v=%b want gnt=0001 idx=0 v=1", gnt, gnt_idx, gnt_valid);
        else n_pass++;
        tick(16'h0001, 1'b1, 1'b0);
        n_checks++;
        if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || timeout !== 1'b0)
            $display("FAIL single_release got gnt=%h v=%b to=%b want gnt=0000 v=0 to=0", gnt, gnt_valid, timeout);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int bad_grant;
        int bad_gap;
        bad_grant = 0;
        bad_gap   = 0;
        tick(16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            tick(16'hFFFF, 1'b0, 1'b0);
            if (gnt_idx !== 4'(i % 16) || gnt !== (16'd1 << (i % 16)) || gnt_valid !== 1'b1) begin
                $display("FAIL rotation_grant step=%0d got idx=%0d gnt=%h want idx=%0d", i, gnt_idx, gnt, i % 16);
                bad_grant++;
            end
            tick(16'hFFFF, 1'b1, 1'b0);
            if (gnt !== 16'h0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                $display("FAIL rotation_gap step=%0d got gnt=%h v=%b to=%b want idle", i, gnt, gnt_valid, timeout);
                bad_gap++;
            end
        end
        n_checks++;
        if (bad_grant !== 0) $display("FAIL rotation_sequence got %0d bad grants want 0", bad_grant);
        else n_pass++;
        n_checks++;
        if (bad_gap !== 0) $display("FAIL rotation_idle_gap got %0d bad gaps want 0", bad_gap);
        else n_pass++;
    endtask

    task automatic test_wrap();
        tick(16'h0000, 1'b0, 1'b1);
        tick(16'h4000, 1'b0, 1'b0);
        tick(16'h4000, 1'b1, 1'b0);
        tick(16'h8001, 1'b0, 1'b0);
        n_checks++;
        if (gnt_idx !== 4'd15 || gnt !== 16'h8000)
            $display("FAIL wrap_first got idx=%0d gnt=%h want idx=15 gnt=8000", gnt_idx, gnt);
        else n_pass++;
        tick(16'h8001, 1'b1, 1'b0);
        tick(16'h8001, 1'b0, 1'b0);
        n_checks++;
        if (gnt_idx !== 4'd0 || gnt !== 16'h0001)
            $display("FAIL wrap_second got idx=%0d gnt=%h want idx=0 gnt=0001", gnt_idx, gnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int held;
        held = 0;
        tick(16'h0000, 1'b0, 1'b1);
        tick(16'h0006, 1'b0, 1'b0);
        while (gnt === 16'h0002 && held < 20) begin
            if (timeout !== 1'b0) $display("FAIL timeout_early got to=1 during hold cycle %0d want 0", held);
            held++;
            tick(16'h0006, 1'b0, 1'b0);
        end
        n_checks++;
        if (held !== MAX_HOLD) $display("FAIL timeout_hold_len got %0d cycles want %0d", held, MAX_HOLD);
        else n_pass++;
        n_checks++;
        if (timeout !== 1'b1 || gnt !== 16'h0000)
            $display("FAIL timeout_pulse got to=%b gnt=%h want to=1 gnt=0000", timeout, gnt);
        else n_pass++;
        tick(16'h0006, 1'b0, 1'b0);
        n_checks++;
        if (gnt_idx !== 4'd2 || timeout !== 1'b0 || gnt_valid !== 1'b1)
            $display("FAIL timeout_next got idx=%0d to=%b v=%b want idx=2 to=0 v=1", gnt_idx, timeout, gnt_valid);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        tick(16'h0000, 1'b0, 1'b1);
        tick(16'h0020, 1'b0, 1'b0);
        n_checks++;
        if (gnt_idx !== 4'd5 || gnt !== 16'h0020)
            $display("FAIL withdraw_grant got idx=%0d gnt=%h want idx=5 gnt=0020", gnt_idx, gnt);
        else n_pass++;
        tick(16'h0000, 1'b0, 1'b0);
        n_checks++;
        if (gnt !== 16'h0000 || timeout !== 1'b0 || gnt_valid !== 1'b0)
            $display("FAIL withdraw_release got gnt=%h to=%b v=%b want gnt=0000 to=0 v=0", gnt, timeout, gnt_valid);
        else n_pass++;
        tick(16'h0000, 1'b1, 1'b0);
        tick(16'h0000, 1'b1, 1'b0);
        n_checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 22'd0)
            $display("FAIL idle_done_ignored got gnt=%h idx=%0d v=%b to=%b want all zero", gnt, gnt_idx, gnt_valid, timeout);
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        tick(16'h0000, 1'b0, 1'b1);
        tick(16'h0200, 1'b0, 1'b0);
        tick(16'h0200, 1'b0, 1'b0);
        n_checks++;
        if (gnt_idx !== 4'd9) $display("FAIL rstbusy_grant got idx=%0d want 9", gnt_idx);
        else n_pass++;
        tick(16'h0200, 1'b0, 1'b1);
        n_checks++;
        if (gnt !== 16'h0000 || timeout !== 1'b0 || gnt_valid !== 1'b0)
            $display("FAIL rstbusy_drop got gnt=%h to=%b v=%b want gnt=0000 to=0 v=0", gnt, timeout, gnt_valid);
        else n_pass++;
        tick(16'h8001, 1'b0, 1'b0);
        n_checks++;
        if (gnt_idx !== 4'd0 || gnt !== 16'h0001)
            $display("FAIL rstbusy_ptr got idx=%0d gnt=%h want idx=0 gnt=0001", gnt_idx, gnt);
        else n_pass++;
        // A reset arriving on the would-be timeout edge must still suppress the pulse.
        tick(16'h8001, 1'b0, 1'b0);
        tick(16'h8001, 1'b0, 1'b0);
        tick(16'h8001, 1'b0, 1'b0);
        tick(16'h8001, 1'b0, 1'b1);
        n_checks++;
        if (timeout !== 1'b0 || gnt !== 16'h0000)
            $display("FAIL rstbusy_no_pulse got to=%b gnt=%h want to=0 gnt=0000", timeout, gnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic [31:0] rv;
        logic        d;
        logic        rs;
        int          n_bad;
        int          n_inv;
        n_bad = 0;
        n_inv = 0;
        r     = 16'h0000;
        tick(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            rv = $urandom();
            case ($urandom_range(0, 4))
                0: r = 16'h0000;
                1: r = 16'd1 << $urandom_range(0, 15);
                2: r = rv[15:0];
                default: r = r;
            endcase
            d  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 79) == 0);
            tick(r, d, rs);
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {e_gnt, e_idx, e_valid, e_to}) begin
                if (n_bad < 8)
                    $display("FAIL random_model cyc=%0d got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                             c, gnt, gnt_idx, gnt_valid, timeout, e_gnt, e_idx, e_valid, e_to);
                n_bad++;
            end
            if (!$onehot0(gnt) || (gnt_valid !== (gnt != 16'h0000)))
                n_inv++;
        end
        n_checks++;
        if (n_bad !== 0) $display("FAIL random_model_total got %0d mismatching cycles want 0", n_bad);
        else n_pass++;
        n_checks++;
        if (n_inv !== 0) $display("FAIL random_invariants got %0d violations want 0", n_inv);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        req   = 16'h0000;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_withdraw();
        test_reset_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares a single 16-entry resource (one word line or slot, selected by a 4:16 one-hot decode) among 16 requesters. It accepts a request vector, grants exactly one requester at a time with rotating priority, and holds the grant until the holder releases or a hold-limit timeout fires. It sits directly in front of the one-hot select decode, sequencing which select line may be driven.

## Interface
Parameters:
- MAX_HOLD, default 15: maximum consecutive BUSY cycles per grant before forced release; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
- req  input  16  request vector; bit i high = requester i wants the resource
- done  input  1  current holder releases the resource this cycle
- gnt  output  16  one-hot grant, or all zeros when idle; registered
- gnt_idx  output  4  binary index of the granted requester; 0 when idle; registered
- gnt_valid  output  1  high exactly when gnt is non-zero
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit

## Operation
- State machine has two states:
  - IDLE: no grant.
  - BUSY: one grant held.
  - Reset state is IDLE.
- Internal state:
  - ptr (4 bits): priority pointer, reset value 0.
  - hold_cnt (4 bits): hold counter, reset value 0.
- Reset values: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0:
  - Pick the first set bit searching ptr, ptr+1, ... ascending, wrapping from 15 to 0.
  - Register gnt/gnt_idx and go to BUSY.
  - Clear hold_cnt to 0.
- BUSY: release occurs on the first of the following. Priority is in listed order; if several hold in the same cycle, the release is normal and timeout stays 0.
  - done=1.
  - req[gnt_idx]=0 (holder withdrew).
  - hold_cnt == MAX_HOLD-1 with no done (timeout).
- On release:
  - Go to IDLE; gnt=0, gnt_idx=0, gnt_valid=0.
  - ptr = (gnt_idx+1) mod 16.
  - timeout=1 for that one cycle only on the timeout cause.
- Otherwise, in BUSY: hold_cnt increments by 1, saturating at 15.
- done while IDLE is ignored.
- req changes on non-held bits during BUSY are ignored.
- The arbiter never re-grants from BUSY directly. An IDLE cycle always separates two grants (break-before-make on the select lines).
- Invariants:
  - gnt is one-hot or zero.
  - gnt == (1 << gnt_idx) whenever gnt_valid=1.

## Timing
- Grant latency:
  - req sampled in IDLE at edge t.
  - gnt visible after edge t+1, i.e. one cycle.
- Release latency:
  - done sampled at edge t.
  - gnt low after edge t+1.
  - Next grant is visible no earlier than after edge t+2.
- Maximum grant occupancy is MAX_HOLD cycles. The timeout pulse coincides with the first cycle gnt=0.
- Back-to-back throughput with continuous requests and done asserted the first cycle of each grant: one grant every 2 cycles.
- Reset mid-BUSY: gnt drops after the reset edge; ptr and hold_cnt return to 0; no timeout pulse.
- Reset has priority over all other inputs in the same cycle.

## Structure
- Package arb16_pkg holds:
  - NREQ=16 and IDXW=4.
  - A state enum with IDLE and BUSY.
  - A function idx_to_onehot(idx).
- Sub-module rr_pick16 is combinational:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: pick_idx[3:0], pick_valid.
  - Implemented as a rotate, then a fixed-priority encode, then an un-rotate.
  - Instantiated once in rr_arbiter16.
- All outputs come from flops in rr_arbiter16; there is no combinational path from req or done to the outputs.

## Test plan
- Single requester:
  - Reset, then req=16'h0001.
  - Expect gnt=16'h0001, gnt_idx=0, gnt_valid=1 one cycle later.
  - Pulse done; gnt=0 on the next cycle.
- Full rotation:
  - req=16'hFFFF held, done asserted the first cycle of each grant.
  - Expect gnt_idx sequence 0,1,2,...,15,0 with one IDLE cycle between grants.
- Wrap-around:
  - After index 14 is released (ptr=15), apply req=16'h8001.
  - Expect grant 15 first, then grant 0 after 15 releases.
- Timeout:
  - MAX_HOLD=4, req=16'h0006, no done.
  - Index 1 is held exactly 4 cycles, then timeout=1 for one cycle with gnt=0.
  - Next grant is index 2.
- Holder withdraw plus ignored done:
  - Grant index 5, then drop req[5] with done=0.
  - Expect release next cycle with timeout=0.
  - done pulsed while IDLE produces no change.
- Reset mid-BUSY:
  - Assert reset while index 9 is held.
  - Expect gnt=0, timeout=0 next cycle.
  - Then req=16'h8001 grants index 0 (ptr reset to 0).
